// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the data-memory path: fun3 codes, responder FSM states, latched request.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package riscv_pkg;

  // RV32I load/store width and sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Request fields held from accept until the response cycle
  typedef struct packed {
    logic        write;
    logic [2:0]  fun3;
    logic [1:0]  addr_lo;
    logic [31:0] wdata;
    logic        err;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Lane formatting for data memory: store byte-enables/replicated data, load extract/extend, width/alignment error.
// Latency: purely combinational.
// Backpressure: none; the caller decides when outputs are used.
module dmem_lane_fmt
  import riscv_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  fun3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ldata,
  output logic        fmt_err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        width_ok;
  logic        misaligned;

  // Store side: lane enables from address, data replicated so every lane carries the value
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    case (fun3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      F3_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = wdata;
      end
    endcase
  end

  // Load side: pick the addressed byte/half, then sign- or zero-extend
  always_comb begin
    byte_sel = rword[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (fun3)
      F3_B:    ldata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ldata = {24'd0, byte_sel};
      F3_H:    ldata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ldata = {16'd0, half_sel};
      F3_W:    ldata = rword;
      default: ldata = 32'd0;
    endcase
  end

  // Illegal width for the direction, or a half/word access not on its natural boundary
  always_comb begin
    case (fun3)
      F3_B, F3_H, F3_W: width_ok = 1'b1;
      F3_BU, F3_HU:     width_ok = ~write;
      default:          width_ok = 1'b0;
    endcase
    misaligned = (((fun3 == F3_H) || (fun3 == F3_HU)) && addr_lo[0]) ||
                 ((fun3 == F3_W) && (addr_lo != 2'b00));
    fmt_err = ~width_ok | misaligned;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time against an internal word array.
// Latency: accept at t, resp_valid pulse at t+LATENCY (LATENCY legal 1..15).
// Backpressure: req_ready only in IDLE; mem_stall freezes the pipeline from accept until the response cycle.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_fun3,
  output logic        req_ready,
  output logic        mem_stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  // BUSY holds LATENCY-1 cycles; the counter reaches 0 on the last of them
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  dmem_state_t   state;
  logic [3:0]    cnt;
  dmem_req_t     req_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          range_err;
  logic          fmt_write;
  logic [2:0]    fmt_fun3;
  logic [1:0]    fmt_addr_lo;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   ldata;
  logic          fmt_err;

  assign accept    = (state == IDLE) && req_valid;
  assign range_err = (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign rword     = mem[idx_q];

  // In IDLE the formatter checks the incoming request; afterwards it works on the latched one
  always_comb begin
    fmt_write   = req_q.write;
    fmt_fun3    = req_q.fun3;
    fmt_addr_lo = req_q.addr_lo;
    if (state == IDLE) begin
      fmt_write   = req_write;
      fmt_fun3    = req_fun3;
      fmt_addr_lo = req_addr[1:0];
    end
  end

  dmem_lane_fmt u_lane_fmt (
    .write     (fmt_write),
    .fun3      (fmt_fun3),
    .addr_lo   (fmt_addr_lo),
    .wdata     (req_q.wdata),
    .rword     (rword),
    .be        (be),
    .wdata_rep (wdata_rep),
    .ldata     (ldata),
    .fmt_err   (fmt_err)
  );

  // Control FSM and latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the request and its error verdict so inputs may change after accept
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      req_q.write   <= req_write;
      req_q.fun3    <= req_fun3;
      req_q.addr_lo <= req_addr[1:0];
      req_q.wdata   <= req_wdata;
      req_q.err     <= fmt_err | range_err;
      idx_q         <= req_addr[AW+1:2];
    end
  end

  // Store commit on the RESP edge; a reset in that cycle cancels it. Array is never cleared.
  always_ff @(posedge clk) begin
    if (!reset && (state == RESP) && req_q.write && !req_q.err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

  // Handshake and response outputs; data/err forced to 0 outside the response pulse
  always_comb begin
    req_ready  = (state == IDLE);
    mem_stall  = accept || (state == BUSY);
    resp_valid = (state == RESP);
    resp_err   = resp_valid && req_q.err;
    resp_rdata = 32'd0;
    if (resp_valid && !req_q.write && !req_q.err) begin
      resp_rdata = ldata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances at LATENCY 2, 1 and 4 sharing one clock.
// Latency: responses checked against an expected-result queue as they appear.
// Backpressure: requests wait on req_ready with a bounded cycle budget.
module tb_dmem_responder;
  import riscv_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [2:0]  req_fun3   [3];
  logic        req_ready  [3];
  logic        mem_stall  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_fun3(req_fun3[0]),
    .req_ready(req_ready[0]), .mem_stall(mem_stall[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_fun3(req_fun3[1]),
    .req_ready(req_ready[1]), .mem_stall(mem_stall[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_fun3(req_fun3[2]),
    .req_ready(req_ready[2]), .mem_stall(mem_stall[2]), .resp_valid(resp_valid[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Every response pulse is matched against the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (resp_valid[d] === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp dut%0d: got resp_valid=1, required no response", d);
        end else begin
          e = sb_q.pop_front();
          if (e.d != d) begin
            errors++;
            $display("FAIL resp_source: got response from dut%0d, required dut%0d", d, e.d);
          end
          checks++;
          if (resp_rdata[d] !== e.rdata) begin
            errors++;
            $display("FAIL resp_rdata dut%0d: got %h, required %h", d, resp_rdata[d], e.rdata);
          end
          checks++;
          if (resp_err[d] !== e.err) begin
            errors++;
            $display("FAIL resp_err dut%0d: got %b, required %b", d, resp_err[d], e.err);
          end
        end
      end
    end
  end

  task automatic drive_req(input int d, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3);
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_fun3[d]  = f3;
    req_valid[d] = 1'b1;
  endtask

  task automatic push_exp(input int d, input logic [31:0] rd, input logic er);
    exp_t e;
    e.d     = d;
    e.rdata = rd;
    e.err   = er;
    sb_q.push_back(e);
  endtask

  // Issue one request, wait for accept, then wait until its response has been consumed
  task automatic run_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    drive_req(d, w, a, wd, f3);
    push_exp(d, exp_rd, exp_err);
    n = 0;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL resp_timeout dut%0d addr %h: got %0d pending, required 0", d, a, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      drive_req(d, 1'b0, 32'd0, 32'd0, F3_W);
      req_valid[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || mem_stall[d] !== 1'b0 || resp_valid[d] !== 1'b0 ||
          resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got rdy=%b stall=%b vld=%b rdata=%h err=%b, required 1 0 0 0 0",
                 d, req_ready[d], mem_stall[d], resp_valid[d], resp_rdata[d], resp_err[d]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load_w();
    run_req(0, 1'b1, 32'h10, 32'hDEADBEEF, F3_W, 32'd0, 1'b0);
    // Timed load: accept cycle, one BUSY cycle, then the response
    drive_req(0, 1'b0, 32'h10, 32'd0, F3_W);
    push_exp(0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1 || mem_stall[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL lat2_accept: got rdy=%b stall=%b vld=%b, required 1 1 0",
               req_ready[0], mem_stall[0], resp_valid[0]);
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b0 || mem_stall[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL lat2_busy: got rdy=%b stall=%b vld=%b, required 0 1 0",
               req_ready[0], mem_stall[0], resp_valid[0]);
    end
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b0 || mem_stall[0] !== 1'b0 || resp_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL lat2_resp: got rdy=%b stall=%b vld=%b, required 0 0 1",
               req_ready[0], mem_stall[0], resp_valid[0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_byte();
    run_req(0, 1'b1, 32'h13, 32'hAAAAAA80, F3_B,  32'd0,        1'b0);
    run_req(0, 1'b0, 32'h13, 32'd0,        F3_B,  32'hFFFFFF80, 1'b0);
    run_req(0, 1'b0, 32'h13, 32'd0,        F3_BU, 32'h00000080, 1'b0);
    run_req(0, 1'b0, 32'h10, 32'd0,        F3_W,  32'h80ADBEEF, 1'b0);
    run_req(0, 1'b0, 32'h10, 32'd0,        F3_B,  32'hFFFFFFEF, 1'b0);
    run_req(0, 1'b0, 32'h11, 32'd0,        F3_BU, 32'h000000BE, 1'b0);
  endtask

  task automatic test_half();
    run_req(0, 1'b1, 32'h12, 32'h55558001, F3_H,  32'd0,        1'b0);
    run_req(0, 1'b0, 32'h12, 32'd0,        F3_H,  32'hFFFF8001, 1'b0);
    run_req(0, 1'b0, 32'h12, 32'd0,        F3_HU, 32'h00008001, 1'b0);
    run_req(0, 1'b0, 32'h10, 32'd0,        F3_H,  32'hFFFFBEEF, 1'b0);
    run_req(0, 1'b0, 32'h10, 32'd0,        F3_W,  32'h8001BEEF, 1'b0);
  endtask

  task automatic test_errors();
    logic [31:0] oor;
    oor = DEPTH * 4;
    run_req(0, 1'b0, 32'h11, 32'd0, F3_W,   32'd0, 1'b1);
    run_req(0, 1'b0, 32'h13, 32'd0, F3_H,   32'd0, 1'b1);
    run_req(0, 1'b0, 32'h13, 32'd0, F3_HU,  32'd0, 1'b1);
    run_req(0, 1'b0, 32'h10, 32'd0, 3'b011, 32'd0, 1'b1);
    run_req(0, 1'b0, oor,    32'd0, F3_W,   32'd0, 1'b1);
    // Rejected stores: out of range (would alias word 4), misaligned, and a load-only width
    run_req(0, 1'b1, oor + 32'h10, 32'h00000000, F3_W,  32'd0, 1'b1);
    run_req(0, 1'b1, 32'h11,       32'h0000FFFF, F3_H,  32'd0, 1'b1);
    run_req(0, 1'b1, 32'h10,       32'h00000000, F3_BU, 32'd0, 1'b1);
    run_req(0, 1'b0, 32'h10,       32'd0,        F3_W,  32'h8001BEEF, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_req(1, 1'b1, 32'h4, 32'h11223344, F3_W, 32'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        drive_req(1, 1'b0, 32'h4, 32'd0, F3_W);
        push_exp(1, 32'h11223344, 1'b0);
      end else if (k == 2) begin
        drive_req(1, 1'b0, 32'h6, 32'd0, F3_H);
        push_exp(1, 32'h00001122, 1'b0);
      end else if (k == 4) begin
        drive_req(1, 1'b0, 32'h4, 32'd0, F3_BU);
        push_exp(1, 32'h00000044, 1'b0);
      end
      @(negedge clk);
      checks++;
      if (mem_stall[1] !== (k % 2 == 0) || req_ready[1] !== (k % 2 == 0) ||
          resp_valid[1] !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL lat1_pattern cycle %0d: got stall=%b rdy=%b vld=%b, required %b %b %b",
                 k, mem_stall[1], req_ready[1], resp_valid[1], (k % 2 == 0), (k % 2 == 0), (k % 2 == 1));
      end
      @(posedge clk);
      #1;
    end
    req_valid[1] = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL lat1_drain: got %0d pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_busy();
    run_req(2, 1'b1, 32'h20, 32'hCAFEF00D, F3_W, 32'd0, 1'b0);
    drive_req(2, 1'b1, 32'h20, 32'h12345678, F3_W);
    @(negedge clk);
    checks++;
    if (req_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL lat4_accept: got rdy=%b, required 1", req_ready[2]);
    end
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    rst[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_stall[2] !== 1'b1) begin
      errors++;
      $display("FAIL lat4_busy_stall: got %b, required 1", mem_stall[2]);
    end
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[2] !== 1'b1 || mem_stall[2] !== 1'b0 || resp_valid[2] !== 1'b0 ||
        resp_rdata[2] !== 32'd0 || resp_err[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_busy: got rdy=%b stall=%b vld=%b rdata=%h err=%b, required 1 0 0 0 0",
               req_ready[2], mem_stall[2], resp_valid[2], resp_rdata[2], resp_err[2]);
    end
    repeat (6) @(posedge clk);
    #1;
    run_req(2, 1'b0, 32'h20, 32'd0, F3_W, 32'hCAFEF00D, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d]       = 1'b1;
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      req_fun3[d]  = F3_W;
    end
    test_reset();
    test_store_load_w();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_busy();
    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
